fetch_sequencer: RTL and testbench

Single-clock controller that sequences the instruction pointer through fetch, execute and advance. Drives the pointer's update and reset strobes and its adjustment value. Issues instruction fetches to memory using a request/acknowledge handshake, and handles sequential advance, taken branches, halt/restart and a memory-timeout fault. Sits between the pointer, instruction memory and the execute stage.

---
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: walks the instruction pointer through clear, fetch,
// execute, adjust and update, with halt/restart and a memory-timeout fault.
// Every output is a register loaded from a decode of the next state, so each
// strobe appears in the same cycle the FSM shows the matching state.
//
// Memory handshake: mem_req_o stays high with a stable mem_addr_o for every
// FETCH cycle. A cycle with mem_ack_i high completes the fetch, and
// mem_data_i is captured in that cycle. mem_req_o drops in the next cycle.
// mem_ack_i is ignored whenever the FSM is not in FETCH.
module fetch_sequencer #(
    parameter int WORD_WIDTH  = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [WORD_WIDTH-1:0] ip_i,
    output logic [WORD_WIDTH-1:0] ip_adj_o,
    output logic                  ip_update_o,
    output logic                  ip_reset_o,
    output logic [WORD_WIDTH-1:0] mem_addr_o,
    output logic                  mem_req_o,
    input  logic                  mem_ack_i,
    input  logic [WORD_WIDTH-1:0] mem_data_i,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic                  instr_valid_o,
    input  logic                  exec_done_i,
    input  logic                  branch_taken_i,
    input  logic [WORD_WIDTH-1:0] branch_offset_i,
    input  logic                  halt_i,
    input  logic                  restart_i,
    output logic                  halted_o,
    output logic                  fault_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        CLR    = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        ADJ    = 3'd3,
        UPDATE = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW:0] TMO = (CW + 1)'(MEM_TIMEOUT);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW:0]           cnt_inc;
    logic [WORD_WIDTH-1:0] ip_adj_q, ip_adj_d;
    logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic                  ip_update_q, ip_update_d;
    logic                  ip_reset_q, ip_reset_d;
    logic                  mem_req_q, mem_req_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  halted_q, halted_d;
    logic                  fault_q, fault_d;

    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ip_adj_d   = ip_adj_q;
        instr_d    = instr_q;
        mem_addr_d = ip_i;
        case (state_q)
            // Reset leaves CLR with ip_reset low; the first cycle out of
            // reset stays in CLR to raise the pulse, the second moves on.
            CLR: begin
                mem_addr_d = '0;
                if (ip_reset_q) state_d = FETCH;
            end
            FETCH: begin
                if (mem_ack_i) begin
                    instr_d = mem_data_i;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                    if (MEM_TIMEOUT != 0 && cnt_inc == TMO) state_d = FAULT;
                end
            end
            EXEC: begin
                if (exec_done_i) begin
                    ip_adj_d = branch_taken_i ? branch_offset_i : WORD_WIDTH'(1);
                    state_d  = ADJ;
                end
            end
            ADJ: state_d = UPDATE;
            // The pointer takes ip_adj on the same edge that leaves UPDATE,
            // so the first fetch address is the sum, not the stale ip.
            UPDATE: begin
                mem_addr_d = ip_i + ip_adj_q;
                state_d    = halt_i ? HALT : FETCH;
            end
            HALT: if (restart_i) state_d = FETCH;
            FAULT: if (restart_i) state_d = CLR;
            default: state_d = CLR;
        endcase
        if (state_d == FETCH && state_q != FETCH) cnt_d = '0;
        mem_req_d     = (state_d == FETCH);
        instr_valid_d = (state_d == EXEC);
        ip_update_d   = (state_d == UPDATE);
        ip_reset_d    = (state_d == CLR);
        halted_d      = (state_d == HALT);
        fault_d       = (state_d == FAULT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= CLR;
            cnt_q         <= '0;
            ip_adj_q      <= '0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            ip_update_q   <= 1'b0;
            ip_reset_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ip_adj_q      <= ip_adj_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            ip_update_q   <= ip_update_d;
            ip_reset_q    <= ip_reset_d;
            mem_req_q     <= mem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    assign ip_adj_o      = ip_adj_q;
    assign ip_update_o   = ip_update_q;
    assign ip_reset_o    = ip_reset_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_req_o     = mem_req_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign halted_o      = halted_q;
    assign fault_o       = fault_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, randomized instruction
// stream against an address-arithmetic reference, and hand-written timeout,
// halt/restart and mid-fetch reset sequences.
module tb_fetch_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] ip_q = 16'h5555;
    logic [W-1:0] ip_adj;
    logic         ip_update;
    logic         ip_reset;
    logic [W-1:0] mem_addr;
    logic         mem_req;
    logic         mem_ack = 1'b0;
    logic [W-1:0] mem_data = '0;
    logic [W-1:0] instr;
    logic         instr_valid;
    logic         exec_done = 1'b0;
    logic         branch_taken = 1'b0;
    logic [W-1:0] branch_offset = '0;
    logic         halt = 1'b0;
    logic         restart = 1'b0;
    logic         halted;
    logic         fault;
    logic [2:0]   state_dbg;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_fetch_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic prev_upd = 1'b0;
    logic prev_rst = 1'b0;

    typedef struct {
        logic [W-1:0] data;
        int           lat;
        int           elat;
        logic         taken;
        logic [W-1:0] off;
        logic         hlt;
        int           gap;
        logic [W-1:0] exp_addr;
        logic [W-1:0] exp_adj;
    } vec_t;

    vec_t vecs[8];

    fetch_sequencer #(.WORD_WIDTH(W), .MEM_TIMEOUT(15)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .ip_i           (ip_q),
        .ip_adj_o       (ip_adj),
        .ip_update_o    (ip_update),
        .ip_reset_o     (ip_reset),
        .mem_addr_o     (mem_addr),
        .mem_req_o      (mem_req),
        .mem_ack_i      (mem_ack),
        .mem_data_i     (mem_data),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .exec_done_i    (exec_done),
        .branch_taken_i (branch_taken),
        .branch_offset_i(branch_offset),
        .halt_i         (halt),
        .restart_i      (restart),
        .halted_o       (halted),
        .fault_o        (fault),
        .state_o        (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction pointer that the sequencer controls.
    always @(posedge clk) begin
        if (ip_reset) ip_q <= '0;
        else if (ip_update) ip_q <= ip_q + ip_adj;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Strobes: never together, never two cycles in a row.
    always @(negedge clk) begin
        if (!reset && (ip_update || ip_reset))
            check("strobe_shape", W'({ip_update & ip_reset, ip_update & prev_upd, ip_reset & prev_rst}), '0);
        prev_upd <= ip_update;
        prev_rst <= ip_reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req: mem_req 0 after 40 cycles, required 1");
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ip_adj"}, ip_adj, '0);
        check({name, "_mem_addr"}, mem_addr, '0);
        check({name, "_instr"}, instr, '0);
        check({name, "_strobes"}, W'({ip_update, ip_reset, mem_req, instr_valid, halted, fault}), '0);
    endtask

    // One instruction, entered at the negedge where its fetch is visible.
    // gap > 0 checks cycles since the previous fetch started.
    task automatic run_instr(input logic [W-1:0] data, input int lat, input int elat,
                             input logic taken, input logic [W-1:0] off, input logic hlt,
                             input int gap, input logic [W-1:0] exp_adj);
        bit found;
        logic [W-1:0] exp_addr;
        wait_req(found);
        if (!found) return;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: expected-address queue empty, required one entry");
        end else begin
            exp_addr = exp_q.pop_front();
            check("fetch_addr", mem_addr, exp_addr);
        end
        if (gap > 0) check("instr_period", W'(cyc - last_fetch_cyc), W'(gap));
        last_fetch_cyc = cyc;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("fetch_wait", W'({mem_req, fault}), W'(2'b10));
        end
        mem_ack = 1'b1;
        mem_data = data;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_data = W'($urandom);
        check("exec_entry", W'({instr_valid, mem_req}), W'(2'b10));
        check("instr", instr, data);
        for (int i = 0; i < elat; i++) begin
            restart = 1'($urandom_range(0, 1));
            halt = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("exec_hold", W'({instr_valid, mem_req, halted, fault}), W'(4'b1000));
            check("exec_instr", instr, data);
        end
        restart = 1'b0;
        exec_done = 1'b1;
        branch_taken = taken;
        branch_offset = off;
        halt = hlt;
        @(negedge clk);
        exec_done = 1'b0;
        branch_taken = 1'($urandom_range(0, 1));
        branch_offset = W'($urandom);
        check("adj_value", ip_adj, exp_adj);
        check("adj_strobes", W'({ip_update, instr_valid, ip_reset, mem_req}), '0);
        @(negedge clk);
        check("update_strobe", W'({ip_update, ip_reset, mem_req}), W'(3'b100));
        check("update_adj", ip_adj, exp_adj);
        @(negedge clk);
        halt = 1'b0;
        if (hlt) begin
            check("halted", W'({halted, mem_req, ip_update}), W'(3'b100));
            repeat (2) begin
                @(negedge clk);
                check("halt_hold", W'({halted, mem_req}), W'(2'b10));
            end
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            check("restart_fetch", W'({mem_req, ip_reset, halted}), W'(3'b100));
        end else begin
            check("next_fetch", W'({mem_req, ip_update}), W'(2'b10));
        end
    endtask

    initial begin
        logic [W-1:0] addr;
        logic [W-1:0] adj;
        logic [W-1:0] off;
        logic [W-1:0] data;
        logic         taken;
        logic         hlt;
        int           lat;
        int           elat;
        int           gap;
        bit           found;

        //                data      lat elat taken off      hlt gap addr      adj
        vecs[0] = '{16'h1234,  0,  0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0001};
        vecs[1] = '{16'h5A01,  0,  0, 1'b1, 16'hFFFE, 1'b0, 4, 16'h0001, 16'hFFFE};
        vecs[2] = '{16'h5A02,  0,  0, 1'b1, 16'h0000, 1'b0, 4, 16'hFFFF, 16'h0000};
        vecs[3] = '{16'h5A03,  0,  0, 1'b0, 16'h1234, 1'b0, 4, 16'hFFFF, 16'h0001};
        vecs[4] = '{16'h5A04,  3,  2, 1'b1, 16'h0010, 1'b0, 4, 16'h0000, 16'h0010};
        vecs[5] = '{16'h5A05, 14,  0, 1'b0, 16'h0000, 1'b0, 9, 16'h0010, 16'h0001};
        vecs[6] = '{16'h5A06,  0,  1, 1'b0, 16'h0000, 1'b1, 18, 16'h0011, 16'h0001};
        vecs[7] = '{16'h5A07,  0,  0, 1'b1, 16'h0100, 1'b0, 0, 16'h0012, 16'h0100};

        // Reset and release.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("release_clr", W'({ip_reset, mem_req}), W'(2'b10));
        @(negedge clk);
        check("release_fetch", W'({ip_reset, mem_req}), W'(2'b01));
        check("release_addr", mem_addr, '0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(vecs[i].exp_addr);
            run_instr(vecs[i].data, vecs[i].lat, vecs[i].elat, vecs[i].taken, vecs[i].off,
                      vecs[i].hlt, vecs[i].gap, vecs[i].exp_adj);
        end

        // Timeout with ack withheld: fault after the 15th wait cycle.
        wait_req(found);
        check("tmo_addr", mem_addr, 16'h0112);
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            check("tmo_wait", W'({mem_req, fault}), W'(2'b10));
        end
        @(negedge clk);
        check("tmo_fault", W'({fault, mem_req, ip_update, ip_reset, halted}), W'(5'b10000));
        @(negedge clk);
        check("fault_hold", W'({fault, mem_req}), W'(2'b10));
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("fault_restart_clr", W'({ip_reset, fault, mem_req}), W'(3'b100));
        @(negedge clk);
        check("fault_restart_fetch", W'({ip_reset, mem_req}), W'(2'b01));

        // Randomized stream against the address model.
        addr = '0;
        gap = 0;
        for (int n = 0; n < 40; n++) begin
            data = W'($urandom);
            lat = $urandom_range(0, 6);
            if ($urandom_range(0, 9) == 0) lat = 14;
            elat = $urandom_range(0, 3);
            taken = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: off = 16'h0000;
                1: off = 16'hFFFF;
                default: off = W'($urandom);
            endcase
            hlt = ($urandom_range(0, 7) == 0);
            adj = taken ? off : 16'h0001;
            exp_q.push_back(addr);
            run_instr(data, lat, elat, taken, off, hlt, gap, adj);
            addr = addr + adj;
            gap = hlt ? 0 : 4 + lat + elat;
        end

        // Reset during an outstanding fetch, then a late ack.
        wait_req(found);
        check("mid_fetch_addr", mem_addr, addr);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_data = 16'hBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_clr", W'({ip_reset, instr_valid, mem_req}), W'(3'b100));
        check("late_ack_instr", instr, '0);
        @(negedge clk);
        check("mid_reset_fetch", W'({ip_reset, mem_req}), W'(2'b01));
        exp_q.push_back(16'h0000);
        run_instr(16'hC0DE, 1, 0, 1'b0, 16'h0000, 1'b0, 0, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
